// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter feeding one register-file write port, with a
// pending-write scoreboard that tracks registers with an outstanding write.
`default_nettype none

module regfile_wb_arbiter #(
    parameter int RR_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_addr,
    output logic        write_reg,
    output logic [4:0]  write_reg_addr,
    output logic [31:0] write_reg_data,
    output logic [31:0] pending
);

    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } state_t;

    state_t      state_q;
    logic        write_reg_q;
    logic [4:0]  write_reg_addr_q;
    logic [31:0] write_reg_data_q;
    logic [31:0] pending_q;
    logic [31:0] pending_d;

    logic        xfer_a;
    logic        xfer_b;
    logic [4:0]  xfer_addr;
    logic [31:0] xfer_data;

    // Grants are combinational; with fixed priority A always wins a tie.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (rst_n) begin
            if (a_valid && b_valid) begin
                if ((RR_EN != 0) && (state_q == LAST_A)) begin
                    b_ready = 1'b1;
                end else begin
                    a_ready = 1'b1;
                end
            end else begin
                a_ready = a_valid;
                b_ready = b_valid;
            end
        end
    end

    assign xfer_a    = a_valid && a_ready;
    assign xfer_b    = b_valid && b_ready;
    assign xfer_addr = xfer_a ? a_addr : b_addr;
    assign xfer_data = xfer_a ? a_data : b_data;

    // Set is applied after clear so a fresh producer wins over a retiring write.
    always_comb begin
        pending_d = pending_q;
        if (write_reg_q) begin
            pending_d[write_reg_addr_q] = 1'b0;
        end
        if (issue_valid && (issue_addr != 5'd0)) begin
            pending_d[issue_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= LAST_B;
            write_reg_q      <= 1'b0;
            write_reg_addr_q <= 5'd0;
            write_reg_data_q <= 32'd0;
            pending_q        <= 32'd0;
        end else begin
            pending_q   <= pending_d;
            write_reg_q <= (xfer_a || xfer_b) && (xfer_addr != 5'd0);
            if (xfer_a || xfer_b) begin
                write_reg_addr_q <= xfer_addr;
                write_reg_data_q <= xfer_data;
                state_q          <= xfer_a ? LAST_A : LAST_B;
            end
        end
    end

    assign write_reg      = write_reg_q;
    assign write_reg_addr = write_reg_addr_q;
    assign write_reg_data = write_reg_data_q;
    assign pending        = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// Drives a round-robin and a fixed-priority instance side by side and checks both
// against a rule-level reference model of grants, writeback and scoreboard.
`default_nettype none

module tb_regfile_wb_arbiter;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } txn_t;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic        a_valid [2];
    logic        a_ready [2];
    logic [4:0]  a_addr [2];
    logic [31:0] a_data [2];
    logic        b_valid [2];
    logic        b_ready [2];
    logic [4:0]  b_addr [2];
    logic [31:0] b_data [2];
    logic        write_reg [2];
    logic [4:0]  write_reg_addr [2];
    logic [31:0] write_reg_data [2];
    logic [31:0] pending [2];

    // Source transaction queues: a source keeps presenting its head until granted.
    txn_t aq [2][$];
    txn_t bq [2][$];

    // Reference model state, index 0 = round-robin DUT, 1 = fixed-priority DUT.
    bit          m_last_a [2];
    bit          m_wr [2];
    logic [4:0]  m_wa [2];
    logic [31:0] m_wd [2];
    bit   [31:0] m_pend [2];

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.RR_EN(1)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid[0]), .a_ready(a_ready[0]), .a_addr(a_addr[0]), .a_data(a_data[0]),
        .b_valid(b_valid[0]), .b_ready(b_ready[0]), .b_addr(b_addr[0]), .b_data(b_data[0]),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .write_reg(write_reg[0]), .write_reg_addr(write_reg_addr[0]),
        .write_reg_data(write_reg_data[0]), .pending(pending[0])
    );

    regfile_wb_arbiter #(.RR_EN(0)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid[1]), .a_ready(a_ready[1]), .a_addr(a_addr[1]), .a_data(a_data[1]),
        .b_valid(b_valid[1]), .b_ready(b_ready[1]), .b_addr(b_addr[1]), .b_data(b_data[1]),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .write_reg(write_reg[1]), .write_reg_addr(write_reg_addr[1]),
        .write_reg_data(write_reg_data[1]), .pending(pending[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    function automatic void grant(input int k, output bit ga, output bit gb);
        bit av = (aq[k].size() > 0);
        bit bv = (bq[k].size() > 0);
        ga = 1'b0;
        gb = 1'b0;
        if (rst_n) begin
            if (av && bv) begin
                if (k == 0 && m_last_a[k]) gb = 1'b1;
                else                       ga = 1'b1;
            end else begin
                ga = av;
                gb = bv;
            end
        end
    endfunction

    task automatic present();
        for (int k = 0; k < 2; k++) begin
            a_valid[k] = (aq[k].size() > 0);
            b_valid[k] = (bq[k].size() > 0);
            if (aq[k].size() > 0) begin
                a_addr[k] = aq[k][0].addr;
                a_data[k] = aq[k][0].data;
            end
            if (bq[k].size() > 0) begin
                b_addr[k] = bq[k][0].addr;
                b_data[k] = bq[k][0].data;
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_last_a[k] = 1'b0;
            m_wr[k]     = 1'b0;
            m_wa[k]     = 5'd0;
            m_wd[k]     = 32'd0;
            m_pend[k]   = 32'd0;
        end
    endtask

    // One clock cycle: compare at the falling edge, advance the model at the rising edge.
    task automatic step();
        bit   ga, gb;
        txn_t t;
        present();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            grant(k, ga, gb);
            chk("a_ready", k, {31'd0, a_ready[k]}, {31'd0, ga});
            chk("b_ready", k, {31'd0, b_ready[k]}, {31'd0, gb});
            chk("write_reg", k, {31'd0, write_reg[k]}, {31'd0, m_wr[k]});
            chk("pending", k, pending[k], m_pend[k]);
            if (m_wr[k]) begin
                chk("wr_addr", k, {27'd0, write_reg_addr[k]}, {27'd0, m_wa[k]});
                chk("wr_data", k, write_reg_data[k], m_wd[k]);
            end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            grant(k, ga, gb);
            if (!rst_n) begin
                m_last_a[k] = 1'b0;
                m_wr[k]     = 1'b0;
                m_wa[k]     = 5'd0;
                m_wd[k]     = 32'd0;
                m_pend[k]   = 32'd0;
            end else begin
                if (m_wr[k]) m_pend[k][m_wa[k]] = 1'b0;
                if (issue_valid && issue_addr != 5'd0) m_pend[k][issue_addr] = 1'b1;
                m_wr[k] = 1'b0;
                if (ga || gb) begin
                    t = ga ? aq[k].pop_front() : bq[k].pop_front();
                    m_wr[k]     = (t.addr != 5'd0);
                    m_wa[k]     = t.addr;
                    m_wd[k]     = t.data;
                    m_last_a[k] = ga;
                end
            end
        end
        #1;
    endtask

    task automatic push_a(input logic [4:0] addr, input logic [31:0] data);
        for (int k = 0; k < 2; k++) aq[k].push_back('{addr, data});
    endtask

    task automatic push_b(input logic [4:0] addr, input logic [31:0] data);
        for (int k = 0; k < 2; k++) bq[k].push_back('{addr, data});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        issue_addr  = 5'd0;
        for (int k = 0; k < 2; k++) begin
            a_valid[k] = 1'b0; a_addr[k] = 5'd0; a_data[k] = 32'd0;
            b_valid[k] = 1'b0; b_addr[k] = 5'd0; b_data[k] = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Held in reset with a source valid: no grant, all outputs cleared.
        push_a(5'd3, 32'h1111_1111);
        step();
        rst_n = 1'b1;
        step();
        step();

        // Single-source writeback, latency one cycle.
        do_reset();
        push_a(5'd5, 32'hDEAD_BEEF);
        step();
        chk("single_data", 0, write_reg_data[0], 32'hDEAD_BEEF);
        chk("single_we", 1, {31'd0, write_reg[1]}, 32'd1);
        step();
        step();

        // Contention: alternating on round-robin, A-first on fixed priority.
        do_reset();
        push_a(5'd1, 32'hA000_0001); push_a(5'd3, 32'hA000_0003);
        push_b(5'd2, 32'hB000_0002); push_b(5'd4, 32'hB000_0004);
        repeat (5) step();
        do_reset();
        push_a(5'd1, 32'hA1); push_a(5'd3, 32'hA3); push_a(5'd5, 32'hA5);
        push_b(5'd6, 32'hB6);
        repeat (5) step();

        // x0 writes and x0 issues are dropped.
        push_b(5'd0, 32'h0000_1234);
        issue_valid = 1'b1; issue_addr = 5'd0;
        step();
        issue_valid = 1'b0;
        step();
        chk("x0_pending", 0, pending[0], 32'd0);

        // Scoreboard: set, clear by writeback, set wins over same-cycle clear.
        issue_valid = 1'b1; issue_addr = 5'd7;
        step();
        issue_valid = 1'b0;
        step();
        step();
        push_a(5'd7, 32'h7777_7777);
        step();
        issue_valid = 1'b1; issue_addr = 5'd7;
        step();
        issue_valid = 1'b0;
        chk("set_wins", 0, {31'd0, pending[0][7]}, 32'd1);
        step();
        step();

        // Reset in the middle of traffic drops the captured write and the scoreboard.
        issue_valid = 1'b1; issue_addr = 5'd12;
        push_a(5'd9, 32'h9999_9999);
        step();
        issue_valid = 1'b0;
        do_reset();
        chk("rst_we", 0, {31'd0, write_reg[0]}, 32'd0);
        chk("rst_pend", 1, pending[1], 32'd0);
        push_a(5'd10, 32'hA10); push_b(5'd11, 32'hB11);
        repeat (3) step();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 60) != 0);
            for (int k = 0; k < 2; k++) begin
                if (aq[k].size() < 3 && $urandom_range(0, 1) == 1)
                    aq[k].push_back('{5'($urandom_range(0, 31)), $urandom});
                if (bq[k].size() < 3 && $urandom_range(0, 1) == 1)
                    bq[k].push_back('{5'($urandom_range(0, 31)), $urandom});
            end
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_addr  = 5'($urandom_range(0, 31));
            step();
        end
        rst_n = 1'b1;
        issue_valid = 1'b0;
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
